// File: rtl/bytemask_rmw_pkg.sv
// Shared types for the byte-masked read-modify-write memory.
//   state_t    : controller state (IDLE accepts requests, MERGE commits a partial write)
//   RMW_CNT_W  : width of the saturating RMW completion counter
//   merge_byte : selects the new byte when its enable is set, else keeps the old one
package bytemask_rmw_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  localparam int RMW_CNT_W = 8;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/bytemask_rmw_mem.sv
// Word array, one synchronous read port and one full-word write port.
// No reset on contents; rdata only changes when re is asserted.
//   clk          : clock
//   we/waddr/wdata : full-word write
//   re/raddr     : read request, data appears on rdata after the edge
//   rdata        : registered read data
module bytemask_rmw_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] ram [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    if (re) rdata <= ram[raddr];
  end

endmodule

// File: rtl/bytemask_rmw.sv
// Byte-enable write front end over a memory that only supports full-word
// writes. Full-mask writes go straight in; partial masks read the old word,
// merge for one cycle (MERGE, req_ready low) and write the merged word back.
//   clk, rst_n     : clock, async active-low reset
//   req_*          : valid/ready request (write flag, addr, byte enables, data)
//   rsp_valid/data : one-cycle read response, data held between responses
//   busy           : high during MERGE
//   rmw_cnt        : saturating count of committed partial writes
module bytemask_rmw
  import bytemask_rmw_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy,
  output logic [RMW_CNT_W-1:0]  rmw_cnt
);

  localparam int BE_W = DATA_W / 8;

  state_t               state_q, state_d;
  logic                 accept, be_full, be_none, partial;
  logic [ADDR_W-1:0]    addr_q;
  logic [BE_W-1:0]      be_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    mem_rdata, merged, hold_q;
  logic                 mem_we, mem_re;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 rsp_valid_q;
  logic [RMW_CNT_W-1:0] cnt_q;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == MERGE);
  assign accept    = req_valid && req_ready;
  assign be_full   = &req_be;
  assign be_none   = ~|req_be;
  assign partial   = !be_full && !be_none;

  // The shared read port serves both reads and the old-word fetch of a
  // partial write. Neither overlaps a write: writes happen either on a
  // full-mask accept (no read that cycle) or in MERGE (nothing accepted),
  // so the array never needs read/write forwarding.
  assign mem_re    = accept && (!req_write || partial);
  assign mem_we    = (accept && req_write && be_full) || (state_q == MERGE);
  assign mem_waddr = (state_q == MERGE) ? addr_q : req_addr;
  assign mem_wdata = (state_q == MERGE) ? merged : req_wdata;

  // In MERGE the read port still holds the old word fetched at accept.
  for (genvar i = 0; i < BE_W; i++) begin : g_merge
    assign merged[8*i +: 8] = merge_byte(mem_rdata[8*i +: 8], wdata_q[8*i +: 8], be_q[i]);
  end

  bytemask_rmw_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (req_addr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && req_write && partial) state_d = MERGE;
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The array read register is also disturbed by old-word fetches, so the
  // visible response is muxed against a resettable hold register.
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_valid_q ? mem_rdata : hold_q;
  assign rmw_cnt   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      hold_q      <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= accept && !req_write;
      hold_q      <= rsp_data;
      if (accept && req_write && partial) begin
        addr_q  <= req_addr;
        be_q    <= req_be;
        wdata_q <= req_wdata;
      end
      if (state_q == MERGE && cnt_q != {RMW_CNT_W{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_bytemask_rmw.sv
module tb_bytemask_rmw;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_write;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_be;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic [7:0]    rmw_cnt;

  bytemask_rmw #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .rmw_cnt(rmw_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem_m [2**AW];
  int            cnt_m;
  logic [DW-1:0] last_rsp;
  int            cyc;
  int            checks, errors;
  logic          mon_en;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference merge as mask arithmetic over whole words.
  function automatic logic [DW-1:0] ref_merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                              input logic [BW-1:0] be);
    logic [DW-1:0] mask;
    mask = '0;
    for (int i = 0; i < BW; i++) if (be[i]) mask = mask | (DW'(8'hFF) << (8 * i));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Monitor: pops an expected response whenever the DUT presents one,
  // otherwise checks rsp_data is being held.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_latency", DW'(cyc), DW'(e.cyc));
          last_rsp = e.data;
        end
      end else begin
        chk("rsp_hold", rsp_data, last_rsp);
      end
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] be,
                       input logic [DW-1:0] d, output int stalls);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_be = be; req_wdata = d;
    stalls = 0;
    while (!req_ready && stalls < 8) begin
      @(negedge clk);
      stalls++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end else if (!w) begin
      sb.push_back('{mem_m[a], cyc + 1});
    end else if (be != '0) begin
      mem_m[a] = ref_merge(mem_m[a], d, be);
      if (be != '1 && cnt_m < 255) cnt_m++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmw_cnt", DW'(rmw_cnt), DW'(cnt_m));
    chk("busy_idle", DW'(busy), 32'd0);
    chk("sb_empty", DW'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0;
    last_rsp = '0;
    sb.delete();
    #1;
    chk("rst_ready", DW'(req_ready), 32'd1);
    chk("rst_rsp_valid", DW'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rmw_cnt", DW'(rmw_cnt), 32'd0);
    chk("rst_busy", DW'(busy), 32'd0);
    mon_en = 1'b1;
  endtask

  initial begin
    int st;
    logic [DW-1:0] saved;
    checks = 0; errors = 0; cyc = 0; mon_en = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    last_rsp = '0; cnt_m = 0;
    do_reset();

    // Known contents everywhere so random reads have a reference.
    for (int a = 0; a < 2**AW; a++) issue(1'b1, AW'(a), '1, $urandom, st);

    // Full write then read back.
    issue(1'b1, 4'd3, 4'hF, 32'hDEADBEEF, st);
    issue(1'b0, 4'd3, 4'h0, 32'h0, st);
    drain();

    // Partial write: ready low for exactly one cycle, merged value read back.
    issue(1'b1, 4'd3, 4'b0101, 32'h11223344, st);
    @(negedge clk);
    chk("merge_ready_low", DW'(req_ready), 32'd0);
    chk("merge_busy", DW'(busy), 32'd1);
    @(negedge clk);
    chk("merge_ready_back", DW'(req_ready), 32'd1);
    chk("merge_model", mem_m[3], 32'hDE22BE44);
    issue(1'b0, 4'd3, 4'h0, 32'h0, st);
    drain();

    // Read offered immediately after a partial write is held off one cycle.
    issue(1'b1, 4'd5, 4'b1010, 32'hCAFEF00D, st);
    issue(1'b0, 4'd5, 4'h0, 32'h0, st);
    chk("read_stall", DW'(st), 32'd1);
    drain();

    // Zero-mask write: no stall, no change.
    issue(1'b1, 4'd3, 4'h0, 32'h55555555, st);
    issue(1'b0, 4'd3, 4'h0, 32'h0, st);
    chk("be0_no_stall", DW'(st), 32'd0);
    drain();

    // Full write immediately followed by partial write and read of same addr.
    issue(1'b1, 4'd9, 4'hF, 32'h01020304, st);
    issue(1'b1, 4'd9, 4'b1000, 32'hFF000000, st);
    issue(1'b0, 4'd9, 4'h0, 32'h0, st);
    drain();

    // Reset during MERGE drops the pending merge.
    issue(1'b1, 4'd7, 4'hF, 32'hAAAAAAAA, st);
    saved = mem_m[7];
    issue(1'b1, 4'd7, 4'b0011, 32'h12345678, st);
    @(negedge clk);
    chk("pre_reset_busy", DW'(busy), 32'd1);
    mem_m[7] = saved;
    do_reset();
    issue(1'b0, 4'd7, 4'h0, 32'h0, st);
    drain();

    // Counter saturation.
    for (int i = 0; i < 255; i++) issue(1'b1, AW'($urandom), 4'b0011, $urandom, st);
    drain();
    chk("sat_255", DW'(rmw_cnt), 32'd255);
    issue(1'b1, 4'd1, 4'b0110, $urandom, st);
    drain();
    chk("sat_hold", DW'(rmw_cnt), 32'd255);

    // Random mix, back-to-back.
    for (int i = 0; i < 400; i++) begin
      logic [BW-1:0] be;
      case ($urandom_range(0, 3))
        0: be = '0;
        1: be = '1;
        default: be = BW'($urandom);
      endcase
      issue(1'($urandom), AW'($urandom), be, $urandom, st);
    end
    drain();
    for (int a = 0; a < 2**AW; a++) issue(1'b0, AW'(a), '0, '0, st);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
